alu_acc_seq: RTL and testbench
==============================

# alu_acc_seq

Parametrised sequential ALU with accumulator; successor to the fixed 16-bit add/sub/xor ALU. It accepts one operation per start/done handshake and writes the result plus status flags into an output accumulator register. Operations are add, subtract, and, or, xor, accumulate, clear, and a multi-cycle shift-add multiply. It sits between the register file / operand bus and the datapath writeback in the CPU core.

## Interface
- WIDTH, 16, datapath width in bits (>= 4)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A, sampled on accepted start
- b  in  WIDTH  operand B, sampled on accepted start
- op  in  3  operation code, sampled on accepted start
- start  in  1  request; accepted only when busy=0
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: out/flags updated
- out  out  WIDTH  accumulator (result register)
- zero, negative, carry, overflow  out  1 each  status flags, updated with out

## Operation
- Op codes: 000 ADD a+b; 001 SUB a-b (a+~b+1); 010 XOR; 011 AND; 100 OR; 101 MUL (low WIDTH bits of unsigned a*b); 110 ACC b+out; 111 CLR out=0.
- Reset values: out=0, zero=0, negative=0, carry=0, overflow=0, busy=0, done=0, state IDLE.
- FSM states IDLE, EXEC, MUL:
  - IDLE: start=1 latches a, b, op.
  - IDLE goes to MUL when op=MUL, else to EXEC.
  - EXEC: one cycle; writes out/flags; returns to IDLE.
  - MUL: one multiplier bit per cycle, LSB first, for WIDTH cycles. The partial product is kept 2*WIDTH wide internally. On the last cycle it writes out/flags and returns to IDLE.
- busy=1 in EXEC and MUL. start while busy is ignored; no queueing.
- done is registered and high the cycle after the write. The FSM is already in IDLE in that cycle, so start asserted in the done cycle is accepted (back-to-back).
- ACC uses the out value at the moment of the write; this is the previous result.
- Flags:
  - zero = (result==0).
  - negative = result[WIDTH-1].
  - ADD/ACC: carry = carry-out; overflow = signed overflow.
  - SUB: carry = carry-out of a+~b+1 (1 = no borrow); overflow = signed overflow.
  - XOR/AND/OR: carry=0, overflow=0.
  - MUL: carry = 1 if upper WIDTH product bits are nonzero; overflow=0.
  - CLR: out=0, zero=1, other flags 0.
- Operand inputs may change freely after acceptance; only the latched copies are used.

## Timing
- Cycle 0: start=1 with busy=0 is accepted.
- Single-cycle ops: busy=1 in cycle 1. out/flags are valid and done=1 in cycle 2. Latency 2.
- MUL: busy=1 in cycles 1..WIDTH. out/flags are valid and done=1 in cycle WIDTH+1.
- out/flags hold their value between operations. They change only on a write or on rst.
- rst has priority over everything, including mid-MUL. The next cycle shows reset values; the aborted op produces no done and no partial result reaches out.
- rst and start in the same cycle: start is discarded.

## Structure
- Shared package alu_pkg holds:
  - op code constants OP_ADD..OP_CLR;
  - state encodings ST_IDLE, ST_EXEC, ST_MUL;
  - the default WIDTH.
- Sub-module addsub_n:
  - parametrised WIDTH combinational adder/subtractor with cin;
  - outputs sum, carry-out and signed overflow;
  - reused for ADD, SUB, ACC and the MUL accumulate step.
- Top level holds the FSM, operand latches, the multiply counter ($clog2(WIDTH)+1 bits), the partial-product register and the accumulator/flag registers.

## Test plan
- ADD a=0x7FFF b=0x0001 (WIDTH=16) -> cycle 2: out=0x8000, negative=1, overflow=1, carry=0, done pulse of exactly 1 cycle.
- SUB a=0x0003 b=0x0005 -> out=0xFFFE, carry=0, negative=1, overflow=0. Then SUB a=0x8000 b=0x0001 -> out=0x7FFF, overflow=1, carry=1.
- MUL a=0x0123 b=0x0010 -> busy for 16 cycles, done in cycle 17, out=0x1230, carry=0. A start pulse with op=ADD during busy is ignored and out is unchanged by it.
- MUL a=0x1000 b=0x0010 -> out=0x0000, zero=1, carry=1.
- Back-to-back sequence, each start issued in the previous done cycle:
  - CLR, then ACC b=0x0005, then ACC b=0x0005 -> out=0x000A;
  - then XOR a=0xFFFF b=0x00FF -> out=0xFF00, negative=1;
  - no idle cycles between ops.
- rst=1 in cycle 5 of a MUL -> cycle 6: out=0, all flags 0, busy=0, done never pulses. A start in cycle 6 is accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared op codes, FSM state encodings and default datapath width
//            for the sequential accumulator ALU.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ACC = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_n.sv
`default_nettype none
// ============================================================================
// Module   : addsub_n
// Purpose  : Combinational WIDTH-bit adder/subtractor with carry-in.
//            sub=1 inverts b, so a-b is obtained with sub=1, cin=1.
// Revision : 1.0  initial release
// ============================================================================
module addsub_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  // Signed overflow: both addends share a sign that the sum does not.
  assign ovf         = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule
`default_nettype wire

// File: rtl/alu_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_acc_seq
// Purpose  : Sequential ALU with output accumulator and status flags.
//            Single-cycle ops run in EXEC; MUL is a WIDTH-cycle shift-add
//            using the same adder as the arithmetic ops.
// Revision : 1.0  initial release
// ============================================================================
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt;
  // Upper half accumulates; lower half holds the not-yet-consumed multiplier
  // bits, shifted right one place per cycle.
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic               add_sub;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               add_ovf;

  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               mul_last;

  // Steer the shared adder: partial-product step in MUL, else the latched op.
  always_comb begin
    add_a   = a_q;
    add_b   = b_q;
    add_sub = 1'b0;
    add_cin = 1'b0;
    if (state == ST_MUL) begin
      add_a = prod[2*WIDTH-1:WIDTH];
      add_b = prod[0] ? a_q : '0;
    end else begin
      case (op_q)
        OP_SUB: begin
          add_sub = 1'b1;
          add_cin = 1'b1;
        end
        OP_ACC:  add_a = out;
        default: ;
      endcase
    end
  end

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  assign prod_next = {add_cout, add_sum, prod[WIDTH-1:1]};
  assign mul_last  = (cnt == CNT_W'(WIDTH - 1));

  // Result and carry/overflow selection for the value about to be written.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_ACC: begin
        res   = add_sum;
        res_c = add_cout;
        res_v = add_ovf;
      end
      OP_XOR: res = a_q ^ b_q;
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_MUL: begin
        res   = prod_next[WIDTH-1:0];
        res_c = |prod_next[2*WIDTH-1:WIDTH];
      end
      default: res = '0;
    endcase
  end

  // Control FSM, operand latches, multiply datapath and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt      <= '0;
      prod     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= '0;
            prod  <= {{WIDTH{1'b0}}, b};
            busy  <= 1'b1;
            state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC: begin
          out      <= res;
          zero     <= (res == '0);
          negative <= res[WIDTH-1];
          carry    <= res_c;
          overflow <= res_v;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_MUL: begin
          prod <= prod_next;
          cnt  <= cnt + CNT_W'(1);
          if (mul_last) begin
            out      <= res;
            zero     <= (res == '0);
            negative <= res[WIDTH-1];
            carry    <= res_c;
            overflow <= res_v;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_acc_seq
// Purpose  : Self-checking bench for alu_acc_seq (WIDTH=16): directed cases,
//            reset behaviour and randomized ops against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_acc_seq;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_ACC = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [2:0]  op_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [15:0] m_out;

  alu_acc_seq #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a_in),
    .b        (b_in),
    .op       (op_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {result, zero, negative, carry, overflow} from plain arithmetic.
  function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic [15:0] acc);
    logic [15:0] r;
    logic        c;
    logic        v;
    int          sx;
    int          sy;
    int          sacc;
    int unsigned ux;
    int unsigned uy;
    int unsigned p;
    sx   = $signed(x);
    sy   = $signed(y);
    sacc = $signed(acc);
    ux   = x;
    uy   = y;
    c    = 1'b0;
    v    = 1'b0;
    case (o)
      3'd0: begin
        r = x + y;
        c = (ux + uy) > 32'd65535;
        v = (sx + sy > 32767) || (sx + sy < -32768);
      end
      3'd1: begin
        r = x - y;
        c = (ux >= uy);
        v = (sx - sy > 32767) || (sx - sy < -32768);
      end
      3'd2: r = x ^ y;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: begin
        p = ux * uy;
        r = p[15:0];
        c = (p > 32'd65535);
      end
      3'd6: begin
        r = acc + y;
        c = (int'(acc) + uy) > 65535;
        v = (sacc + sy > 32767) || (sacc + sy < -32768);
      end
      default: r = 16'h0000;
    endcase
    model = {r, (r == 16'h0000), r[15], c, v};
  endfunction

  // Issue one op at the current falling edge; returns at the falling edge of
  // its done cycle. pulse>0 injects an ADD start request in that busy cycle.
  task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input int pulse);
    logic [19:0] exp;
    int          lat;
    int          cyc;
    exp   = model(o, x, y, m_out);
    lat   = (o == OP_MUL) ? 17 : 2;
    op_in = o;
    a_in  = x;
    b_in  = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
    op_in = 3'($urandom);
    cyc   = 1;
    chk("busy_c1", busy, 1);
    chk("done_c1", done, 0);
    chk("hold_c1", out, m_out);
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == pulse) begin
        start = 1'b1;
        op_in = OP_ADD;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("out", out, exp[19:4]);
    chk("zero", zero, exp[3]);
    chk("negative", negative, exp[2]);
    chk("carry", carry, exp[1]);
    chk("overflow", overflow, exp[0]);
    chk("busy_done", busy, 0);
    m_out = exp[19:4];
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_flags"}, {zero, negative, carry, overflow}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Start a MUL and assert rst during its cycle 5; returns in cycle 6.
  task automatic abort_mul();
    op_in = OP_MUL;
    a_in  = 16'h0123;
    b_in  = 16'h0010;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_c5_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_out = 16'h0000;
    chk_reset_state("abort_c6");
  endtask

  initial begin
    logic [15:0] edges [4];
    logic        saw_done;
    logic [2:0]  ro;
    logic [15:0] ra;
    logic [15:0] rb;
    edges[0] = 16'h0000;
    edges[1] = 16'h7FFF;
    edges[2] = 16'h8000;
    edges[3] = 16'hFFFF;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 16'h0000;
    b_in  = 16'h0000;
    op_in = OP_ADD;
    m_out = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed arithmetic corners.
    do_op(OP_ADD, 16'h7FFF, 16'h0001, 0);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    do_op(OP_SUB, 16'h0003, 16'h0005, 0);
    @(negedge clk);
    do_op(OP_SUB, 16'h8000, 16'h0001, 0);
    @(negedge clk);
    do_op(OP_MUL, 16'h0123, 16'h0010, 5);
    @(negedge clk);
    do_op(OP_MUL, 16'h1000, 16'h0010, 0);

    // Back-to-back: each start issued in the previous done cycle.
    do_op(OP_CLR, 16'h1234, 16'h5678, 0);
    do_op(OP_ACC, 16'h0000, 16'h0005, 0);
    do_op(OP_ACC, 16'h0000, 16'h0005, 0);
    chk("acc_sum", out, 16'h000A);
    do_op(OP_XOR, 16'hFFFF, 16'h00FF, 0);
    chk("xor_val", out, 16'hFF00);
    @(negedge clk);

    // Reset mid-MUL: no done may follow and out stays cleared.
    abort_mul();
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    chk("abort_out_held", out, 0);

    // Reset mid-MUL, then a new op issued in the first post-reset cycle.
    do_op(OP_ADD, 16'h1111, 16'h2222, 0);
    @(negedge clk);
    abort_mul();
    do_op(OP_ADD, 16'h0F0F, 16'h0101, 0);
    @(negedge clk);

    // rst and start together: the start is discarded.
    rst   = 1'b1;
    start = 1'b1;
    op_in = OP_ADD;
    a_in  = 16'h0001;
    b_in  = 16'h0001;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    m_out = 16'h0000;
    chk("rst_start_busy", busy, 0);
    @(negedge clk);
    chk("rst_start_done", done, 0);
    chk("rst_start_out", out, 0);

    // Randomized ops, mixing boundary operands and back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      do_op(ro, ra, rb, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
